// File: rtl/inference_sequencer_pkg.sv
// Shared types and constants for the inference run controller: FSM states, RAM owner
// encoding and the ASCII bytes sent back over the UART.
package inference_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_SEND,
    S_SEND_WAIT
  } state_t;

  typedef enum logic {
    OWN_LOADER = 1'b0,
    OWN_CNN    = 1'b1
  } owner_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ERR   = 8'h45;
  localparam int         IMG_SIZE    = 784;

  // Class indices outside 0..9 are reported as '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [7:0] digit);
    if (digit > 8'd9) begin
      return ASCII_QMARK;
    end
    return ASCII_ZERO + digit;
  endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Bundle of loader, CNN, shared-RAM and UART-TX signals around the inference sequencer.
// master = the sequencer, slave = the surrounding system.
interface inference_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int DIGIT_W = 4
);
  logic               weights_loaded;
  logic               ld_wr_en;
  logic [ADDR_W-1:0]  ld_wr_addr;
  logic [DATA_W-1:0]  ld_wr_data;
  logic               image_loaded;
  logic [ADDR_W-1:0]  cnn_rd_addr;
  logic               cnn_done;
  logic [DIGIT_W-1:0] cnn_digit;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wr_data;
  logic               ram_wr_en;
  logic               cnn_start;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic               busy;
  logic [DIGIT_W-1:0] result_digit;
  logic               result_valid;
  logic               overrun;
  logic               timeout_err;

  modport master (
    input  weights_loaded, ld_wr_en, ld_wr_addr, ld_wr_data, image_loaded,
           cnn_rd_addr, cnn_done, cnn_digit, tx_busy,
    output ram_addr, ram_wr_data, ram_wr_en, cnn_start, tx_data, tx_start,
           busy, result_digit, result_valid, overrun, timeout_err
  );

  modport slave (
    output weights_loaded, ld_wr_en, ld_wr_addr, ld_wr_data, image_loaded,
           cnn_rd_addr, cnn_done, cnn_digit, tx_busy,
    input  ram_addr, ram_wr_data, ram_wr_en, cnn_start, tx_data, tx_start,
           busy, result_digit, result_valid, overrun, timeout_err
  );

endinterface

// File: rtl/inference_sequencer_cycle_watchdog.sv
// Cycle counter guarding a CNN run: counts enabled cycles since the last clear and
// flags the cycle on which LIMIT enabled cycles have elapsed.
module cycle_watchdog #(
  parameter int LIMIT = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count_reg;

  assign expired = en && (count_reg == CNT_W'(LIMIT - 1));

  // Counter parks on the terminal value so a stalled owner cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Run controller for one MNIST inference: arbitrates the image RAM port, launches the CNN,
// guards it with a watchdog and reports the predicted digit as one ASCII byte.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic                  clk,
  input logic                  rst,
  inference_sequencer_if.master bus
);

  state_t             state_reg;
  owner_t             owner_reg;
  logic               cnn_start_reg;
  logic               tx_start_reg;
  logic [7:0]         tx_data_reg;
  logic [DIGIT_W-1:0] result_digit_reg;
  logic               result_valid_reg;
  logic               overrun_reg;
  logic               timeout_err_reg;
  logic               wd_clr;
  logic               wd_en;
  logic               wd_expired;

  assign wd_clr = (state_reg == S_START);
  assign wd_en  = (state_reg == S_RUN);

  cycle_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Outside IDLE the CNN owns the port and every loader write is suppressed.
  assign bus.ram_addr    = (owner_reg == OWN_CNN) ? bus.cnn_rd_addr : bus.ld_wr_addr;
  assign bus.ram_wr_en   = (owner_reg == OWN_CNN) ? 1'b0 : bus.ld_wr_en;
  assign bus.ram_wr_data = bus.ld_wr_data;

  assign bus.cnn_start    = cnn_start_reg;
  assign bus.tx_start     = tx_start_reg;
  assign bus.tx_data      = tx_data_reg;
  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.result_digit = result_digit_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.overrun      = overrun_reg;
  assign bus.timeout_err  = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      owner_reg        <= OWN_LOADER;
      cnn_start_reg    <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= '0;
      result_digit_reg <= '0;
      result_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      cnn_start_reg    <= 1'b0;
      result_valid_reg <= 1'b0;

      if ((state_reg != S_IDLE) && (bus.ld_wr_en || bus.image_loaded)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          owner_reg <= OWN_LOADER;
          if (bus.image_loaded && bus.weights_loaded) begin
            state_reg     <= S_START;
            owner_reg     <= OWN_CNN;
            cnn_start_reg <= 1'b1;
          end
        end

        S_START: begin
          state_reg <= S_RUN;
        end

        // A done pulse on the expiry cycle still counts as a valid result.
        S_RUN: begin
          if (bus.cnn_done) begin
            result_digit_reg <= bus.cnn_digit;
            result_valid_reg <= 1'b1;
            tx_data_reg      <= digit_to_ascii(8'(bus.cnn_digit));
            state_reg        <= S_SEND;
          end else if (wd_expired) begin
            timeout_err_reg <= 1'b1;
            tx_data_reg     <= ASCII_ERR;
            state_reg       <= S_SEND;
          end
        end

        S_SEND: begin
          if (!bus.tx_busy) begin
            tx_start_reg <= 1'b1;
            state_reg    <= S_SEND_WAIT;
          end
        end

        // First cycle here is the tx_start cycle; the UART has not raised busy yet.
        S_SEND_WAIT: begin
          if (tx_start_reg) begin
            tx_start_reg <= 1'b0;
          end else if (!bus.tx_busy) begin
            state_reg <= S_IDLE;
            owner_reg <= OWN_LOADER;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          owner_reg <= OWN_LOADER;
        end
      endcase
    end
  end

endmodule
